// File: rtl/adaptive_filter_pkg.sv
// Shared types and the saturation helper for the time-multiplexed LMS filter.
// sat() clamps a wide signed value to the two's complement range of out_w bits.
package adaptive_filter_pkg;

  typedef enum logic [1:0] {
    MODE_LMS       = 2'd0,
    MODE_SIGN_ERR  = 2'd1,
    MODE_SIGN_SIGN = 2'd2,
    MODE_FREEZE    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILTER = 2'd1,
    ERROR  = 2'd2,
    UPDATE = 2'd3
  } state_e;

  localparam int unsigned SAT_W = 64;

  function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] v,
                                                  input int unsigned out_w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (out_w - 32'd1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/adaptive_filter_tdm_sat_mac.sv
// Shared arithmetic for the filter: one signed multiplier used for the FIR MAC and for
// the weight-update term, plus the second multiply by mu and the saturating weight add.
module sat_mac
  import adaptive_filter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input  logic                    filter_i,
  input  mode_e                   mode_i,
  input  logic signed [WIDTH-1:0] w_i,
  input  logic signed [WIDTH-1:0] x_i,
  input  logic signed [WIDTH-1:0] e_i,
  input  logic        [WIDTH-1:0] mu_i,
  output logic signed [2*WIDTH:0] prod_o,
  output logic signed [WIDTH-1:0] w_upd_o,
  output logic                    ovf_o
);

  localparam int PW = 2*WIDTH + 1;
  localparam int TW = 2*WIDTH + 2;

  logic signed [WIDTH:0]    op_a_s;
  logic signed [WIDTH:0]    mu_s;
  logic signed [PW-1:0]     prod_s;
  logic signed [PW-1:0]     prod2_s;
  logic signed [SAT_W-1:0]  mid_raw_s;
  logic signed [SAT_W-1:0]  mid_sat_s;
  logic signed [SAT_W-1:0]  sum_raw_s;
  logic signed [SAT_W-1:0]  sum_sat_s;
  logic signed [WIDTH-1:0]  mid_s;
  logic signed [TW-1:0]     u_s;
  logic                     mid_ovf_s;
  logic                     sum_ovf_s;

  assign mu_s = $signed({1'b0, mu_i});

  // Multiplier operand select: mu takes the e slot in sign-error mode
  always_comb begin
    if (filter_i) begin
      op_a_s = (WIDTH+1)'(w_i);
    end else if (mode_i == MODE_SIGN_ERR) begin
      op_a_s = mu_s;
    end else begin
      op_a_s = (WIDTH+1)'(e_i);
    end
  end

  assign prod_s = PW'(op_a_s) * PW'(x_i);

  // LMS intermediate (e*x)>>>FRAC is held to WIDTH bits before the multiply by mu
  assign mid_raw_s = 64'(prod_s >>> FRAC);
  assign mid_sat_s = sat(mid_raw_s, WIDTH);
  assign mid_s     = $signed(mid_sat_s[WIDTH-1:0]);
  assign mid_ovf_s = (mid_sat_s != mid_raw_s);
  assign prod2_s   = PW'(mid_s) * PW'(mu_s);

  // Weight-update term for the selected algorithm
  always_comb begin
    u_s = '0;
    case (mode_i)
      MODE_LMS: begin
        u_s = TW'(prod2_s >>> FRAC);
      end
      MODE_SIGN_ERR: begin
        if (e_i == '0) begin
          u_s = '0;
        end else if (e_i[WIDTH-1]) begin
          u_s = (-(TW'(prod_s))) >>> FRAC;
        end else begin
          u_s = TW'(prod_s) >>> FRAC;
        end
      end
      MODE_SIGN_SIGN: begin
        if ((e_i == '0) || (x_i == '0)) begin
          u_s = '0;
        end else if (e_i[WIDTH-1] ^ x_i[WIDTH-1]) begin
          u_s = -(TW'(mu_s));
        end else begin
          u_s = TW'(mu_s);
        end
      end
      default: begin
        u_s = '0;
      end
    endcase
  end

  assign sum_raw_s = 64'(w_i) + 64'(u_s);
  assign sum_sat_s = sat(sum_raw_s, WIDTH);
  assign sum_ovf_s = (sum_sat_s != sum_raw_s);

  // Overflow reporting; a full-width filter product can never overflow
  always_comb begin
    if (filter_i) begin
      ovf_o = 1'b0;
    end else if (mode_i == MODE_LMS) begin
      ovf_o = mid_ovf_s | sum_ovf_s;
    end else if (mode_i == MODE_FREEZE) begin
      ovf_o = 1'b0;
    end else begin
      ovf_o = sum_ovf_s;
    end
  end

  assign prod_o  = prod_s;
  assign w_upd_o = $signed(sum_sat_s[WIDTH-1:0]);

endmodule

// File: rtl/adaptive_filter_tdm.sv
// Time-multiplexed LMS adaptive FIR: per accepted sample, TAPS MAC cycles, one error
// cycle and TAPS weight-update cycles, all through the shared sat_mac datapath.
module adaptive_filter_tdm
  import adaptive_filter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8,
  parameter int TAPS  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic signed [WIDTH-1:0]     i_din,
  input  logic signed [WIDTH-1:0]     i_desired,
  input  logic        [WIDTH-1:0]     i_step_size,
  input  logic        [1:0]           i_mode,
  input  logic                        i_ovr,
  input  logic                        i_ovr_clr,
  output logic                        o_valid,
  output logic signed [WIDTH-1:0]     o_dout,
  output logic signed [WIDTH-1:0]     o_error,
  output logic [TAPS-1:0][WIDTH-1:0]  o_weights,
  output logic                        o_ovr
);

  localparam int CW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int AW = 2*WIDTH + $clog2(TAPS);
  localparam int PW = 2*WIDTH + 1;
  localparam logic [CW-1:0] LAST_K = CW'(TAPS - 1);

  state_e                      state_q, state_d;
  logic [CW-1:0]               k_q, k_d;
  logic [TAPS-1:0][WIDTH-1:0]  x_q, x_d;
  logic [TAPS-1:0][WIDTH-1:0]  w_q, w_d;
  logic signed [AW-1:0]        acc_q, acc_d;
  logic signed [WIDTH-1:0]     des_q, des_d;
  logic        [WIDTH-1:0]     mu_q, mu_d;
  mode_e                       mode_q, mode_d;
  logic signed [WIDTH-1:0]     dout_q, dout_d;
  logic signed [WIDTH-1:0]     err_q, err_d;
  logic                        valid_q, valid_d;
  logic                        ovr_q, ovr_d;

  logic                        filter_s;
  logic                        set_s;
  logic signed [WIDTH-1:0]     x_k_s;
  logic signed [WIDTH-1:0]     w_k_s;
  logic signed [PW-1:0]        prod_s;
  logic signed [WIDTH-1:0]     w_upd_s;
  logic                        mac_ovf_s;
  logic signed [SAT_W-1:0]     y_raw_s, y_sat_s, e_raw_s, e_sat_s;
  logic signed [WIDTH:0]       e_wide_s;
  logic                        y_ovf_s, e_ovf_s;

  assign filter_s = (state_q == FILTER);
  assign x_k_s    = $signed(x_q[k_q]);
  assign w_k_s    = $signed(w_q[k_q]);

  sat_mac #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_mac (
    .filter_i (filter_s),
    .mode_i   (mode_q),
    .w_i      (w_k_s),
    .x_i      (x_k_s),
    .e_i      (err_q),
    .mu_i     (mu_q),
    .prod_o   (prod_s),
    .w_upd_o  (w_upd_s),
    .ovf_o    (mac_ovf_s)
  );

  // Output and error computation from the finished accumulator
  always_comb begin
    y_raw_s  = 64'(acc_q >>> FRAC);
    y_sat_s  = sat(y_raw_s, WIDTH);
    y_ovf_s  = (y_sat_s != y_raw_s);
    e_wide_s = (WIDTH+1)'(des_q) - (WIDTH+1)'($signed(y_sat_s[WIDTH-1:0]));
    e_raw_s  = 64'(e_wide_s);
    e_sat_s  = sat(e_raw_s, WIDTH);
    e_ovf_s  = (e_sat_s != e_raw_s);
  end

  // Next-state logic for the sequencer and datapath
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    x_d     = x_q;
    w_d     = w_q;
    acc_d   = acc_q;
    des_d   = des_q;
    mu_d    = mu_q;
    mode_d  = mode_q;
    dout_d  = dout_q;
    err_d   = err_q;
    valid_d = 1'b0;
    set_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          x_d     = {x_q[TAPS-2:0], i_din};
          des_d   = i_desired;
          mu_d    = i_step_size;
          mode_d  = mode_e'(i_mode);
          acc_d   = '0;
          k_d     = '0;
          set_s   = i_ovr;
          state_d = FILTER;
        end else begin
          state_d = IDLE;
        end
      end
      FILTER: begin
        acc_d = acc_q + AW'(prod_s);
        if (k_q == LAST_K) begin
          k_d     = '0;
          state_d = ERROR;
        end else begin
          k_d = k_q + CW'(1);
        end
      end
      ERROR: begin
        dout_d  = $signed(y_sat_s[WIDTH-1:0]);
        err_d   = $signed(e_sat_s[WIDTH-1:0]);
        valid_d = 1'b1;
        set_s   = y_ovf_s | e_ovf_s;
        k_d     = '0;
        state_d = UPDATE;
      end
      UPDATE: begin
        if (mode_q != MODE_FREEZE) begin
          w_d[k_q] = w_upd_s;
          set_s    = mac_ovf_s;
        end else begin
          w_d = w_q;
        end
        if (k_q == LAST_K) begin
          k_d     = '0;
          state_d = IDLE;
        end else begin
          k_d = k_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ovr_d = set_s | (ovr_q & ~i_ovr_clr);
  end

  // State, datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      x_q     <= '0;
      w_q     <= '0;
      acc_q   <= '0;
      des_q   <= '0;
      mu_q    <= '0;
      mode_q  <= MODE_LMS;
      dout_q  <= '0;
      err_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      x_q     <= x_d;
      w_q     <= w_d;
      acc_q   <= acc_d;
      des_q   <= des_d;
      mu_q    <= mu_d;
      mode_q  <= mode_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign o_ready   = (state_q == IDLE);
  assign o_valid   = valid_q;
  assign o_dout    = dout_q;
  assign o_error   = err_q;
  assign o_weights = w_q;
  assign o_ovr     = ovr_q;

endmodule

// File: tb/tb_adaptive_filter_tdm.sv
// Directed bench for adaptive_filter_tdm with WIDTH=16, FRAC=8, TAPS=4; expected values
// are hand-derived from the filter equations.
module tb_adaptive_filter_tdm;

  localparam int WIDTH = 16;
  localparam int FRAC  = 8;
  localparam int TAPS  = 4;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       i_valid;
  logic                       o_ready;
  logic signed [WIDTH-1:0]    i_din;
  logic signed [WIDTH-1:0]    i_desired;
  logic        [WIDTH-1:0]    i_step_size;
  logic        [1:0]          i_mode;
  logic                       i_ovr;
  logic                       i_ovr_clr;
  logic                       o_valid;
  logic signed [WIDTH-1:0]    o_dout;
  logic signed [WIDTH-1:0]    o_error;
  logic [TAPS-1:0][WIDTH-1:0] o_weights;
  logic                       o_ovr;

  int n_tests = 0;
  int n_fail  = 0;
  int vc, rc, vn;
  int acc_cnt, last_i, pulses;
  logic signed [WIDTH-1:0] got_dout, got_err;

  adaptive_filter_tdm #(.WIDTH(WIDTH), .FRAC(FRAC), .TAPS(TAPS)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_din       (i_din),
    .i_desired   (i_desired),
    .i_step_size (i_step_size),
    .i_mode      (i_mode),
    .i_ovr       (i_ovr),
    .i_ovr_clr   (i_ovr_clr),
    .o_valid     (o_valid),
    .o_dout      (o_dout),
    .o_error     (o_error),
    .o_weights   (o_weights),
    .o_ovr       (o_ovr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_valid = 1'b0;
    i_ovr = 1'b0;
    i_ovr_clr = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Issue one sample, then scramble the inputs; returns the cycle (accept edge = 0) in
  // which o_valid and o_ready were seen, and how many cycles o_valid was high.
  task automatic send(input logic signed [15:0] din, input logic signed [15:0] d,
                      input logic [15:0] mu, input logic [1:0] mode,
                      output int vcyc, output int rcyc, output int vcnt);
    i_din = din;
    i_desired = d;
    i_step_size = mu;
    i_mode = mode;
    i_ovr = 1'b0;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    i_din = 16'h7abc;
    i_desired = 16'h8123;
    i_step_size = 16'hffff;
    i_mode = ~mode;
    i_ovr = 1'b1;
    vcyc = -1;
    rcyc = -1;
    vcnt = 0;
    for (int c = 1; c <= 30; c++) begin
      if (o_valid) begin
        vcnt++;
        if (vcyc < 0) begin
          vcyc = c;
          got_dout = o_dout;
          got_err = o_error;
        end
      end
      if (o_ready) begin
        rcyc = c;
        break;
      end
      tick();
    end
    i_ovr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    i_valid = 1'b0;
    i_din = '0;
    i_desired = '0;
    i_step_size = '0;
    i_mode = 2'd0;
    i_ovr = 1'b0;
    i_ovr_clr = 1'b0;
    tick();
    tick();
    check("rst_ready", o_ready, 1);
    check("rst_valid", o_valid, 0);
    check("rst_dout", o_dout, 0);
    check("rst_ovr", o_ovr, 0);
    rst = 1'b0;
    tick();

    // LMS single step and timing
    send(256, 128, 256, 2'd0, vc, rc, vn);
    check("lms_valid_cycle", vc, 6);
    check("lms_valid_pulses", vn, 1);
    check("lms_dout", got_dout, 0);
    check("lms_err", got_err, 128);
    check("lms_ready_cycle", rc, 10);
    check("lms_w0", $signed(o_weights[0]), 128);
    check("lms_w1", $signed(o_weights[1]), 0);
    check("lms_w3", $signed(o_weights[3]), 0);
    check("lms_no_ovr", o_ovr, 0);

    // Freeze after training w0 to 1.0
    do_reset();
    send(256, 256, 256, 2'd0, vc, rc, vn);
    check("train_w0", $signed(o_weights[0]), 256);
    send(64, 0, 256, 2'd3, vc, rc, vn);
    check("frz_dout", got_dout, 64);
    check("frz_err", got_err, -64);
    check("frz_w0", $signed(o_weights[0]), 256);
    check("frz_w1", $signed(o_weights[1]), 0);
    check("frz_ovr", o_ovr, 0);

    // Saturation: sign-sign training with huge mu drives w0,w1 to full scale
    do_reset();
    send(1, 32767, 16'hffff, 2'd2, vc, rc, vn);
    check("sat_train_w0", $signed(o_weights[0]), 32767);
    check("sat_train_ovr", o_ovr, 1);
    send(1, 32767, 16'hffff, 2'd2, vc, rc, vn);
    check("sat_train_w1", $signed(o_weights[1]), 32767);
    i_ovr_clr = 1'b1;
    tick();
    i_ovr_clr = 1'b0;
    check("ovr_clr1", o_ovr, 0);
    send(32767, -32768, 0, 2'd3, vc, rc, vn);
    send(32767, -32768, 0, 2'd3, vc, rc, vn);
    check("sat_dout", got_dout, 32767);
    check("sat_err", got_err, -32768);
    check("sat_ovr", o_ovr, 1);
    check("sat_w0", $signed(o_weights[0]), 32767);
    check("sat_w2", $signed(o_weights[2]), 0);
    tick();
    tick();
    tick();
    check("ovr_sticky", o_ovr, 1);
    i_ovr_clr = 1'b1;
    tick();
    i_ovr_clr = 1'b0;
    check("ovr_clr2", o_ovr, 0);

    // Set beats a simultaneous clear
    i_din = 100;
    i_desired = 0;
    i_step_size = 256;
    i_mode = 2'd0;
    i_ovr = 1'b1;
    i_ovr_clr = 1'b1;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    i_ovr = 1'b0;
    i_ovr_clr = 1'b0;
    check("set_beats_clr", o_ovr, 1);
    check("busy_not_ready", o_ready, 0);
    tick();

    // Reset in the middle of FILTER
    rst = 1'b1;
    #1;
    check("arst_dout", o_dout, 0);
    check("arst_err", o_error, 0);
    check("arst_w0", $signed(o_weights[0]), 0);
    check("arst_w1", $signed(o_weights[1]), 0);
    check("arst_ovr", o_ovr, 0);
    tick();
    rst = 1'b0;
    tick();
    check("arst_ready", o_ready, 1);
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      if (o_valid) pulses++;
      tick();
    end
    check("arst_no_valid", pulses, 0);

    // Sign-sign update, then e = 0 leaves the weight alone
    send(-5, 10, 3, 2'd2, vc, rc, vn);
    check("ss_dout", got_dout, 0);
    check("ss_err", got_err, 10);
    check("ss_w0", $signed(o_weights[0]), -3);
    send(-5, 0, 3, 2'd2, vc, rc, vn);
    check("ss0_err", got_err, 0);
    check("ss0_w0", $signed(o_weights[0]), -3);

    // Held i_valid: one accept every 2*TAPS+2 cycles; i_ovr only counts when accepted
    acc_cnt = 0;
    last_i = 0;
    i_step_size = 1;
    i_mode = 2'd2;
    i_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      i_din = 16'(i * 37 - 500);
      i_desired = 16'(i * 11);
      if (o_ready) begin
        acc_cnt++;
        if (acc_cnt > 1) check("hs_spacing", i - last_i, 10);
        last_i = i;
        i_ovr = (acc_cnt == 4);
      end else begin
        i_ovr = 1'b1;
      end
      tick();
      if (i == 29) check("hs_ovr_ignored", o_ovr, 0);
      if (i == 30) check("hs_ovr_captured", o_ovr, 1);
    end
    i_valid = 1'b0;
    i_ovr = 1'b0;
    check("hs_accepts", acc_cnt, 4);
    rc = -1;
    for (int c = 0; c < 25; c++) begin
      if (o_ready) begin
        rc = c;
        break;
      end
      tick();
    end
    check("hs_drain_ready", (rc >= 0), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
